// File: rtl/complete_arbiter_pkg.sv
// Shared types and defaults for the completion arbiter and its round-robin selector.
// Result types are sized for the default tag and data widths.
package complete_arbiter_pkg;

  localparam int NUM_FU_DEF = 8;
  localparam int CDB_W_DEF  = 3;
  localparam int PR_W_DEF   = 6;
  localparam int XLEN_DEF   = 32;
  localparam int MAX_FU     = 16;

  typedef struct packed {
    logic [PR_W_DEF-1:0] pr;
    logic [XLEN_DEF-1:0] value;
  } fu_result_t;

  typedef struct packed {
    logic                valid;
    logic [PR_W_DEF-1:0] pr;
    logic [XLEN_DEF-1:0] value;
  } cdb_slot_t;

  // Returns the bit position of a one-hot vector; 0 when the vector is empty.
  function automatic int oh_index(input logic [MAX_FU-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_FU; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/complete_arbiter_rr_select.sv
// Rotating-priority single grant: the first request at or after ptr, wrapping,
// found by scanning a doubled request vector shifted down by ptr.
module rr_select #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [N-1:0] rot;
  int           first;
  int           pos;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    pos = first + int'(ptr);
    if (pos >= N) pos = pos - N;
    any = |req;
    gnt = any ? (N'(1) << pos) : '0;
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion stage: one result buffer per FU, up to CDB_W round-robin grants per
// cycle onto registered CDB slots, with squash and per-FU backpressure.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int CDB_W  = CDB_W_DEF,
  parameter int PR_W   = PR_W_DEF,
  parameter int XLEN   = XLEN_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU-1:0][PR_W-1:0]   fu_pr,
  input  logic [NUM_FU-1:0][XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]             fu_stall,
  output logic [CDB_W-1:0]              cdb_valid,
  output logic [CDB_W-1:0][PR_W-1:0]    cdb_pr,
  output logic [CDB_W-1:0][XLEN-1:0]    wb_value
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]           buf_valid;
  logic [NUM_FU-1:0][PR_W-1:0] buf_pr;
  logic [NUM_FU-1:0][XLEN-1:0] buf_value;
  logic [PTR_W-1:0]            rr_ptr;

  logic [CDB_W-1:0][NUM_FU-1:0] remaining;
  logic [CDB_W:0][PTR_W-1:0]    stage_ptr;
  logic [CDB_W-1:0][NUM_FU-1:0] stage_gnt;
  logic [CDB_W-1:0]             stage_any;
  logic [CDB_W-1:0][PTR_W-1:0]  slot_idx;
  logic [NUM_FU-1:0]            grant;

  assign remaining[0] = buf_valid;
  assign stage_ptr[0] = rr_ptr;

  // Each stage resumes the scan just past the previous stage's winner, so slot
  // order follows scan order and the final pointer is last-grant + 1.
  for (genvar k = 0; k < CDB_W; k++) begin : g_stage
    rr_select #(.N(NUM_FU), .PW(PTR_W)) u_sel (
      .req (remaining[k]),
      .ptr (stage_ptr[k]),
      .gnt (stage_gnt[k]),
      .any (stage_any[k])
    );

    assign slot_idx[k] = PTR_W'(oh_index(MAX_FU'(stage_gnt[k])));

    assign stage_ptr[k+1] = !stage_any[k] ? stage_ptr[k] :
                            (slot_idx[k] == PTR_W'(NUM_FU - 1)) ? '0 :
                            slot_idx[k] + 1'b1;

    if (k < CDB_W - 1) begin : g_mask
      assign remaining[k+1] = remaining[k] & ~stage_gnt[k];
    end
  end

  always_comb begin
    grant = '0;
    for (int k = 0; k < CDB_W; k++) begin
      grant = grant | stage_gnt[k];
    end
  end

  assign fu_stall = (reset || squash) ? '0 : (buf_valid & ~grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_pr    <= '0;
      wb_value  <= '0;
    end else if (squash) begin
      buf_valid <= '0;
      cdb_valid <= '0;
      cdb_pr    <= '0;
      wb_value  <= '0;
    end else begin
      rr_ptr <= stage_ptr[CDB_W];
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && (!buf_valid[i] || grant[i])) begin
          buf_valid[i] <= 1'b1;
          buf_pr[i]    <= fu_pr[i];
          buf_value[i] <= fu_value[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      for (int k = 0; k < CDB_W; k++) begin
        cdb_valid[k] <= stage_any[k];
        cdb_pr[k]    <= stage_any[k] ? buf_pr[slot_idx[k]]    : '0;
        wb_value[k]  <= stage_any[k] ? buf_value[slot_idx[k]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: directed FU offers with hand-computed
// per-slot expectations, popped by a monitor whenever a CDB slot is valid.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int NF = NUM_FU_DEF;
  localparam int CW = CDB_W_DEF;
  localparam int PW = PR_W_DEF;
  localparam int XL = XLEN_DEF;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  logic [NF-1:0]         fu_valid;
  logic [NF-1:0][PW-1:0] fu_pr;
  logic [NF-1:0][XL-1:0] fu_value;
  logic [NF-1:0]         fu_stall;
  logic [CW-1:0]         cdb_valid;
  logic [CW-1:0][PW-1:0] cdb_pr;
  logic [CW-1:0][XL-1:0] wb_value;

  logic [3:0]          q_fu_valid;
  logic [3:0][PW-1:0]  q_fu_pr;
  logic [3:0][XL-1:0]  q_fu_value;
  logic [3:0]          q_fu_stall;
  logic [3:0]          q_cdb_valid;
  logic [3:0][PW-1:0]  q_cdb_pr;
  logic [3:0][XL-1:0]  q_wb_value;

  complete_arbiter u_dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_pr(fu_pr), .fu_value(fu_value), .fu_stall(fu_stall),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr), .wb_value(wb_value)
  );

  complete_arbiter #(.NUM_FU(4), .CDB_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(q_fu_valid), .fu_pr(q_fu_pr), .fu_value(q_fu_value), .fu_stall(q_fu_stall),
    .cdb_valid(q_cdb_valid), .cdb_pr(q_cdb_pr), .wb_value(q_wb_value)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [NF-1:0] stall_seen;
  fu_result_t pend [NF][$];
  fu_result_t exp_q [CW][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic offer(input int fu, input int pr, input int val);
    fu_result_t r;
    r.pr    = PW'(pr);
    r.value = XL'(val);
    pend[fu].push_back(r);
  endtask

  task automatic expect_slot(input int slot, input int pr, input int val);
    fu_result_t r;
    r.pr    = PW'(pr);
    r.value = XL'(val);
    exp_q[slot].push_back(r);
  endtask

  // FU model: present the head of each pending queue, hold it while stalled.
  task automatic run_cycles(input int n);
    logic [NF-1:0] acc;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (pend[i].size() > 0) begin
          fu_valid[i] = 1'b1;
          fu_pr[i]    = pend[i][0].pr;
          fu_value[i] = pend[i][0].value;
        end else begin
          fu_valid[i] = 1'b0;
          fu_pr[i]    = '0;
          fu_value[i] = '0;
        end
      end
      #1;
      acc        = fu_valid & ~fu_stall;
      stall_seen = stall_seen | fu_stall;
      @(posedge clock);
      #1;
      for (int i = 0; i < NF; i++) begin
        if (acc[i]) void'(pend[i].pop_front());
      end
    end
  endtask

  always @(negedge clock) begin
    fu_result_t e;
    if (mon_en) begin
      for (int k = 0; k < CW; k++) begin
        if (cdb_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_slot%0d actual pr=%0h value=%0h required none", k, cdb_pr[k], wb_value[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("slot%0d_pr", k), 64'(cdb_pr[k]), 64'(e.pr));
            check($sformatf("slot%0d_value", k), 64'(wb_value[k]), 64'(e.value));
          end
        end else begin
          check($sformatf("slot%0d_idle_zero", k), {cdb_pr[k], wb_value[k]}, 64'd0);
        end
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1;
    squash = 1'b0;
    fu_valid = '0;
    fu_pr = '0;
    fu_value = '0;
    q_fu_valid = '0;
    q_fu_pr = '0;
    q_fu_value = '0;
    stall_seen = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_rr_ptr", 64'(u_dut.rr_ptr), 64'd0);
    check("rst_fu_stall", 64'(fu_stall), 64'd0);

    // Single uncontended result: buffered after one edge, on the CDB after two.
    offer(2, 5, 'hDEAD);
    expect_slot(0, 5, 'hDEAD);
    run_cycles(1);
    check("t1_not_yet_on_cdb", 64'(cdb_valid), 64'd0);
    check("t1_buffered", 64'(u_dut.buf_valid), 64'h04);
    run_cycles(1);
    check("t1_cdb_valid", 64'(cdb_valid), 64'b001);
    check("t1_rr_ptr", 64'(u_dut.rr_ptr), 64'd3);
    run_cycles(1);
    check("t1_no_stall", 64'(stall_seen), 64'd0);

    // All eight FUs, each holding its result for two offers, starting from ptr 0.
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    for (int i = 0; i < NF; i++) begin
      offer(i, i + 1, 'h100 + i);
      offer(i, i + 1, 'h100 + i);
    end
    foreach (exp_q[k]) exp_q[k].delete();
    begin
      int s0 [6] = '{1, 4, 7, 2, 5, 8};
      int s1 [5] = '{2, 5, 8, 3, 6};
      int s2 [5] = '{3, 6, 1, 4, 7};
      foreach (s0[j]) expect_slot(0, s0[j], 'h100 + s0[j] - 1);
      foreach (s1[j]) expect_slot(1, s1[j], 'h100 + s1[j] - 1);
      foreach (s2[j]) expect_slot(2, s2[j], 'h100 + s2[j] - 1);
    end
    run_cycles(1);
    check("t2_stall_first", 64'(fu_stall), 64'hF8);
    run_cycles(1);
    check("t2_stall_second", 64'(fu_stall), 64'hC7);
    run_cycles(8);
    check("t2_rr_ptr_wrap", 64'(u_dut.rr_ptr), 64'd0);

    // Back-to-back stream from FU4.
    stall_seen = '0;
    for (int n = 0; n < 10; n++) begin
      offer(4, 10 + n, 'h400 + n);
      expect_slot(0, 10 + n, 'h400 + n);
    end
    run_cycles(2);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (cdb_valid == 3'b001) cnt++;
      run_cycles(1);
    end
    check("t3_consecutive", 64'(cnt), 64'd10);
    check("t3_no_stall_fu4", 64'(stall_seen[4]), 64'd0);
    check("t3_rr_ptr", 64'(u_dut.rr_ptr), 64'd5);

    // Squash with FUs 0 and 5 buffered and FU3 offering in the squash cycle.
    offer(0, 20, 'h2000);
    offer(5, 21, 'h2100);
    run_cycles(1);
    check("t4_buffered", 64'(u_dut.buf_valid), 64'h21);
    squash = 1'b1;
    offer(3, 22, 'h2200);
    #1;
    check("t4_stall_during_squash", 64'(fu_stall), 64'd0);
    run_cycles(1);
    squash = 1'b0;
    check("t4_cdb_cleared", 64'(cdb_valid), 64'd0);
    check("t4_buf_cleared", 64'(u_dut.buf_valid), 64'd0);
    check("t4_rr_ptr_held", 64'(u_dut.rr_ptr), 64'd5);
    check("t4_stall_after", 64'(fu_stall), 64'd0);
    run_cycles(3);

    // Tag-0 result from FU1 competes with FUs 2..4 for the three slots (ptr 5).
    offer(1, 0, 'h1234);
    offer(2, 30, 'h3000);
    offer(3, 31, 'h3100);
    offer(4, 32, 'h3200);
    expect_slot(0, 0, 'h1234);
    expect_slot(1, 30, 'h3000);
    expect_slot(2, 31, 'h3100);
    expect_slot(0, 32, 'h3200);
    run_cycles(2);
    check("t5_all_slots_used", 64'(cdb_valid), 64'b111);
    check("t5_tag0_pr", 64'(cdb_pr[0]), 64'd0);
    run_cycles(3);

    // Reset with five buffers full and rr_ptr 6.
    offer(5, 40, 'h4000);
    expect_slot(0, 40, 'h4000);
    run_cycles(3);
    offer(0, 41, 'h4100);
    offer(1, 42, 'h4200);
    offer(2, 43, 'h4300);
    offer(3, 44, 'h4400);
    offer(7, 45, 'h4500);
    run_cycles(1);
    check("t6_buffers_full", 64'(u_dut.buf_valid), 64'h8F);
    check("t6_rr_ptr_before", 64'(u_dut.rr_ptr), 64'd6);
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    check("t6_cdb_valid", 64'(cdb_valid), 64'd0);
    check("t6_cdb_pr", 64'(cdb_pr), 64'd0);
    check("t6_wb_value", 64'(wb_value), 64'd0);
    check("t6_rr_ptr", 64'(u_dut.rr_ptr), 64'd0);
    check("t6_buf_valid", 64'(u_dut.buf_valid), 64'd0);
    run_cycles(3);

    // Four FUs, four slots: everything granted in one cycle.
    q_fu_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      q_fu_pr[k]    = PW'(50 + k);
      q_fu_value[k] = XL'(32'h500 + k);
    end
    run_cycles(1);
    q_fu_valid = '0;
    check("t7_stall", 64'(q_fu_stall), 64'd0);
    run_cycles(1);
    check("t7_cdb_valid", 64'(q_cdb_valid), 64'hF);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t7_pr%0d", k), 64'(q_cdb_pr[k]), 64'(50 + k));
      check($sformatf("t7_value%0d", k), 64'(q_wb_value[k]), 64'(32'h500 + k));
    end
    check("t7_rr_ptr", 64'(u_dut4.rr_ptr), 64'd0);
    run_cycles(2);

    for (int k = 0; k < CW; k++) begin
      check($sformatf("drained_slot%0d", k), 64'(exp_q[k].size()), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
